sev_seg_display_arbiter: RTL
============================

// Module: sev_seg_display_arbiter
// PURPOSE
//  Shares the 8-digit seven-segment display between NUM_REQ requesters. Round-robin grant
//  with a minimum dwell time, so no requester flickers the display or starves the others.
//  Output digits/blank feed the seven-segment scan controller. Idle display is blanked.
// PARAMETERS
//  NUM_REQ       4           number of requesters (>=1)
//  DWELL_CYCLES  10_000_000  minimum cycles an owner keeps the display once others are waiting
//  DWELL_W       24          dwell counter width; must satisfy 2**DWELL_W >= DWELL_CYCLES
// PORTS
//  clk       in   1             system clock, all logic on rising edge
//  reset     in   1             asynchronous, active-high reset
//  req       in   NUM_REQ       req[i]=1: requester i wants the display (level)
//  req_data  in   32 x NUM_REQ  unpacked array; req_data[i][4k+3:4k] = digit k of requester i
//  gnt       out  NUM_REQ       one-hot (or zero) grant, registered
//  owner     out  $clog2(NUM_REQ) index of current owner; valid only while |gnt
//  digits    out  4 x 8         unpacked digits[0:7] to the scan controller, registered
//  blank     out  1             1 = no owner, scan controller must drive all anodes off
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, gnt=0, owner=0, digits all 4'h0, blank=1,
//   dwell=0, last=NUM_REQ-1 (so requester 0 wins first).
//  States: IDLE, HOLD, GAP.
//  Winner pick: first asserted req searching last+1, last+2, ... mod NUM_REQ (round-robin).
//  IDLE: blank=1, digits=0. Any req -> HOLD next cycle: gnt[winner]=1, owner=winner,
//   last=winner, dwell=0, blank=0, digits<=req_data[winner]. Latency req->gnt = 1 cycle.
//  HOLD: digits<=req_data[owner] every cycle (live, 1-cycle lag). dwell increments,
//   saturates at DWELL_CYCLES-1; dwell_done = (dwell==DWELL_CYCLES-1).
//   - req[owner]==0            -> GAP (release, regardless of dwell).
//   - dwell_done && |(req & ~gnt) -> GAP (preempt).
//   - otherwise stay; a lone owner keeps the display indefinitely.
//   - both conditions same cycle: treated as release; outcome identical (GAP).
//  GAP (exactly 1 cycle): gnt=0, digits and blank hold last value (no blank flash).
//   Any req -> HOLD with fresh winner (same pick rule, same loads as from IDLE);
//   none -> IDLE (digits cleared, blank=1). Old owner may win again only if alone.
//  Requests arriving/dropping during GAP are sampled in GAP, not earlier.
//  NUM_REQ==1: preempt never fires; behaviour reduces to request/release.
//  gnt, owner, digits, blank all change only on clock edge (except async reset).
//  reset asserted mid-HOLD: outputs return to reset values immediately; no GAP cycle.
// STRUCTURE
//  Package sev_seg_pkg: NUM_DIGITS=8, typedef logic [3:0] digit_t,
//   typedef digit_t digits_t [0:NUM_DIGITS-1], typedef enum {IDLE,HOLD,GAP} disp_arb_state_t.
//  Sub-module rr_priority_picker #(N): combinational; in: req[N], last index; out: any,
//   winner index. Everything else (FSM, dwell counter, output regs) in this module.
// TESTING (bench: NUM_REQ=4, DWELL_CYCLES=8)
//  1 reset then req=4'b0000 for 20 cycles -> gnt=0, blank=1, digits all 0 throughout.
//  2 req=4'b0100, req_data[2]=32'h8765_4321 -> next cycle gnt=4'b0100, owner=2, blank=0,
//    digits[0]=1..digits[7]=8; hold 100 cycles -> no change; drop req -> GAP then IDLE.
//  3 req=4'b0011 from IDLE after reset -> gnt=0001; after 8 HOLD cycles gnt=0, then
//    gnt=0010; after 8 more -> GAP -> gnt=0001 (round-robin alternation, no starvation).
//  4 owner 0 holding, dwell 3, drop req[0] while req[3]=1 -> 1 GAP cycle, digits held,
//    blank=0 -> gnt=1000 with digits=req_data[3].
//  5 change req_data[owner] from 32'h0 to 32'hFFFF_FFFF mid-HOLD -> digits all F one
//    cycle later, gnt unchanged.
//  6 assert reset mid-HOLD between edges -> gnt=0, blank=1, digits=0 before next edge;
//    after release with req=4'b1111 -> requester 0 granted first.

Source files
------------

// File: rtl/sev_seg_display_arbiter_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
package sev_seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  typedef logic [3:0] digit_t;
  typedef digit_t digits_t [0:NUM_DIGITS-1];

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } disp_arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic digits_t unpack_digits(input logic [31:0] w);
    digits_t d;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      d[k] = w[4*k +: 4];
    end
    return d;
  endfunction

endpackage

// File: rtl/sev_seg_display_arbiter_if.sv
// Requester/display bundle between the requesters and the display arbiter.
interface sev_seg_display_arbiter_if
  import sev_seg_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [31:0]        req_data [0:NUM_REQ-1];
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   owner;
  digits_t            digits;
  logic               blank;

  modport master (
    output req, req_data,
    input  gnt, owner, digits, blank
  );

  modport slave (
    input  req, req_data,
    output gnt, owner, digits, blank
  );

endinterface

// File: rtl/sev_seg_display_arbiter_picker.sv
// Combinational round-robin picker: first asserted request after i_last.
module rr_priority_picker
  import sev_seg_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic         o_any,
  output logic [W-1:0] o_winner
);

  // Scan from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    o_any    = |i_req;
    o_winner = '0;
    for (int unsigned k = N; k > 0; k--) begin
      if (i_req[W'((32'(i_last) + k) % N)]) begin
        o_winner = W'((32'(i_last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/sev_seg_display_arbiter.sv
// Round-robin owner of the 8-digit display with minimum dwell and a one-cycle handover gap.
module sev_seg_display_arbiter
  import sev_seg_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DWELL_CYCLES = 10_000_000,
  parameter int unsigned DWELL_W      = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  sev_seg_display_arbiter_if.slave     bus
);

  localparam int unsigned        IDX_W     = idx_width(NUM_REQ);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_CYCLES - 1);

  disp_arb_state_t    r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_last, w_last_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
  digits_t            r_digits, w_digits_nxt;
  logic               r_blank, w_blank_nxt;

  logic               w_any;
  logic [IDX_W-1:0]   w_winner;
  logic               w_dwell_done;
  logic               w_others;

  rr_priority_picker #(
    .N (NUM_REQ),
    .W (IDX_W)
  ) u_picker (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  assign w_dwell_done = (r_dwell == DWELL_MAX);
  assign w_others     = |(bus.req & ~r_gnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_last   <= IDX_W'(NUM_REQ - 1);
      r_dwell  <= '0;
      r_digits <= '{default: '0};
      r_blank  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_owner  <= w_owner_nxt;
      r_last   <= w_last_nxt;
      r_dwell  <= w_dwell_nxt;
      r_digits <= w_digits_nxt;
      r_blank  <= w_blank_nxt;
    end
  end

  // IDLE and GAP share the grant path; GAP differs only in holding the display beforehand.
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    w_dwell_nxt  = r_dwell;
    w_digits_nxt = r_digits;
    w_blank_nxt  = r_blank;
    unique case (r_state)
      HOLD: begin
        w_digits_nxt = unpack_digits(bus.req_data[r_owner]);
        if (!w_dwell_done) w_dwell_nxt = r_dwell + 1'b1;
        if (!bus.req[r_owner] || (w_dwell_done && w_others)) begin
          w_state_nxt = GAP;
          w_gnt_nxt   = '0;
        end
      end
      IDLE, GAP: begin
        if (w_any) begin
          w_state_nxt  = HOLD;
          w_gnt_nxt    = NUM_REQ'(1) << w_winner;
          w_owner_nxt  = w_winner;
          w_last_nxt   = w_winner;
          w_dwell_nxt  = '0;
          w_blank_nxt  = 1'b0;
          w_digits_nxt = unpack_digits(bus.req_data[w_winner]);
        end else begin
          w_state_nxt  = IDLE;
          w_gnt_nxt    = '0;
          w_blank_nxt  = 1'b1;
          w_digits_nxt = '{default: '0};
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.gnt    = r_gnt;
  assign bus.owner  = r_owner;
  assign bus.digits = r_digits;
  assign bus.blank  = r_blank;

endmodule
